// File: rtl/dm_arb_if.sv
// Bus bundle between the two data-memory masters, the arbiter and the memory.
// slave: arbiter side; master: masters/memory side (testbench, CPU glue).
interface dm_arb_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic [DW-1:0] m0_rdata;
    logic          m0_rvalid;
    logic          cpu_stall;

    logic          m1_req;
    logic          m1_lock;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic [DW-1:0] m1_rdata;
    logic          m1_rvalid;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rdata, m0_rvalid, cpu_stall,
        input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rdata, m1_rvalid,
        output mem_addr, mem_din, mem_we,
        input  mem_dout
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rdata, m0_rvalid, cpu_stall,
        output m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rdata, m1_rvalid,
        input  mem_addr, mem_din, mem_we,
        output mem_dout
    );
endinterface

// File: rtl/dm_arb.sv
// Two-master round-robin arbiter for the single-port data memory, with a
// bounded burst lock for master 1. Ports: clk, reset (async, active-low), bus.
module dm_arb #(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int BURST_MAX = 8
) (
    input  logic     clk,
    input  logic     reset,
    dm_arb_if.slave  bus
);
    localparam logic [7:0] BMAX = 8'(BURST_MAX);

    logic          prio;
    logic          locked;
    logic [7:0]    burst_cnt;
    logic          gnt0;
    logic          gnt1;
    logic          at_max;
    logic          lock_clr;
    logic          locked_nxt;
    logic          rd0;
    logic          rd1;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          rvalid0_q;
    logic          rvalid1_q;

    assign at_max = (burst_cnt >= BMAX);

    // Contention only matters when both request; a lone requester always wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!(bus.m0_req && bus.m1_req)) begin
            gnt0 = bus.m0_req;
            gnt1 = bus.m1_req;
        end else if (locked) begin
            gnt1 = !at_max;
            gnt0 = at_max;
        end else begin
            gnt0 = !prio;
            gnt1 = prio;
        end
    end

    assign addr_mux      = gnt1 ? bus.m1_addr : bus.m0_addr;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_din   = gnt1 ? bus.m1_wdata : bus.m0_wdata;
    assign bus.mem_we    = (gnt1 & bus.m1_we) | (gnt0 & bus.m0_we);
    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.cpu_stall = bus.m0_req & ~gnt0;

    assign rd0 = gnt0 & ~bus.m0_we;
    assign rd1 = gnt1 & ~bus.m1_we;

    // Lock survives only while master 1 keeps requesting with lock asserted
    // and master 0 has not been let through.
    assign lock_clr   = ~bus.m1_req | ~bus.m1_lock | gnt0;
    assign locked_nxt = (gnt1 & bus.m1_lock) | (locked & ~lock_clr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio      <= 1'b0;
            locked    <= 1'b0;
            burst_cnt <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            if (gnt0 || gnt1)
                prio <= gnt0;
            locked <= locked_nxt;
            // Only grants taken while master 0 waits count toward the bound.
            if (!locked_nxt)
                burst_cnt <= '0;
            else if (locked && gnt1 && bus.m0_req && !at_max)
                burst_cnt <= burst_cnt + 8'd1;
            rvalid0_q <= rd0;
            rvalid1_q <= rd1;
            if (rd0)
                rdata0_q <= bus.mem_dout;
            if (rd1)
                rdata1_q <= bus.mem_dout;
        end
    end

    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.m0_rvalid = rvalid0_q;
    assign bus.m1_rvalid = rvalid1_q;
endmodule

// File: tb/tb_dm_arb.sv
// Testbench for dm_arb: vector table, directed sequences, random vs model.
// Ports: none (top-level bench).
module tb_dm_arb;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BM = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dm_arb_if #(.AW(AW), .DW(DW)) bus ();

    dm_arb #(.AW(AW), .DW(DW), .BURST_MAX(BM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem     [0:1023];
    logic [31:0] exp_mem [0:1023];

    assign bus.mem_dout = mem[bus.mem_addr];
    always @(posedge clk)
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r0, input bit w0, input int a0,
                         input logic [31:0] d0, input bit r1, input bit lk,
                         input bit w1, input int a1, input logic [31:0] d1);
        bus.m0_req   = r0;
        bus.m0_we    = w0;
        bus.m0_addr  = AW'(a0);
        bus.m0_wdata = d0;
        bus.m1_req   = r1;
        bus.m1_lock  = lk;
        bus.m1_we    = w1;
        bus.m1_addr  = AW'(a1);
        bus.m1_wdata = d1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Pulse reset between clock edges.
    task automatic rst_pulse();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        cyc();
    endtask

    typedef struct {
        bit r0, r1, lk;
        bit g0, g1, st;
    } vec_t;

    vec_t tbl [19];

    // Reference model state: last winner, burst run, expected read returns.
    int          last_win;
    bit          burst_on;
    int          burst_n;
    logic [31:0] e_rd0, e_rd1;
    bit          e_rv0, e_rv1;

    function automatic int pick(bit r0, bit r1);
        if (!r0 && !r1) return -1;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (burst_on) return (burst_n >= BM) ? 0 : 1;
        return (last_win == 0) ? 1 : 0;
    endfunction

    int rv_cnt;
    int w;

    initial begin
        tbl = '{
            '{1,1,0, 1,0,0}, '{1,1,0, 0,1,1}, '{1,1,0, 1,0,0},
            '{1,1,0, 0,1,1}, '{1,1,0, 1,0,0}, '{1,1,0, 0,1,1},
            '{0,1,1, 0,1,0}, '{0,1,1, 0,1,0},
            '{1,1,1, 0,1,1}, '{1,1,1, 0,1,1}, '{1,1,1, 0,1,1},
            '{1,1,1, 0,1,1}, '{1,1,1, 0,1,1}, '{1,1,1, 0,1,1},
            '{1,1,1, 0,1,1}, '{1,1,1, 0,1,1},
            '{1,1,1, 1,0,0}, '{1,1,1, 0,1,1},
            '{0,0,0, 0,0,0}
        };
        for (int i = 0; i < 1024; i++) begin
            mem[i]     <= 32'h1000_0000 + 32'(i * 7);
            exp_mem[i] = 32'h1000_0000 + 32'(i * 7);
        end
        reset = 1'b0;
        idle();
        #2;
        chk("rst_m0_rvalid", bus.m0_rvalid, 0);
        chk("rst_m1_rvalid", bus.m1_rvalid, 0);
        chk("rst_m0_rdata", bus.m0_rdata, 0);
        chk("rst_m1_rdata", bus.m1_rdata, 0);
        drive(1, 0, 5, 0, 1, 0, 0, 9, 0);
        #1;
        chk("rst_comb_m0_gnt", bus.m0_gnt, 1);
        chk("rst_comb_m1_gnt", bus.m1_gnt, 0);
        cyc();
        chk("rst_hold_rvalid", bus.m0_rvalid, 0);
        reset = 1'b1;

        // Both read at once; m0 re-requests so it stalls exactly once.
        #3;
        chk("t1_g0", bus.m0_gnt, 1);
        chk("t1_stall0", bus.cpu_stall, 0);
        chk("t1_addr0", bus.mem_addr, 5);
        cyc();
        chk("t1_rv0", bus.m0_rvalid, 1);
        chk("t1_rd0", bus.m0_rdata, exp_mem[5]);
        bus.m0_addr = 6;
        #3;
        chk("t1_g1", bus.m1_gnt, 1);
        chk("t1_g0_off", bus.m0_gnt, 0);
        chk("t1_stall1", bus.cpu_stall, 1);
        chk("t1_addr1", bus.mem_addr, 9);
        cyc();
        chk("t1_rv1", bus.m1_rvalid, 1);
        chk("t1_rd1", bus.m1_rdata, exp_mem[9]);
        chk("t1_rv0_off", bus.m0_rvalid, 0);
        bus.m1_req = 0;
        #3;
        chk("t1_g0b", bus.m0_gnt, 1);
        chk("t1_stall2", bus.cpu_stall, 0);
        cyc();
        chk("t1_rd0b", bus.m0_rdata, exp_mem[6]);
        idle();

        // Vector table: alternation, then a locked burst hitting the bound.
        rst_pulse();
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].r0, 0, 1, 0, tbl[i].r1, tbl[i].lk, 0, 2, 0);
            #3;
            chk($sformatf("tbl%0d_g0", i), bus.m0_gnt, tbl[i].g0);
            chk($sformatf("tbl%0d_g1", i), bus.m1_gnt, tbl[i].g1);
            chk($sformatf("tbl%0d_st", i), bus.cpu_stall, tbl[i].st);
            chk($sformatf("tbl%0d_we", i), bus.mem_we, 0);
            chk($sformatf("tbl%0d_ad", i), bus.mem_addr, tbl[i].g1 ? 2 : 1);
            cyc();
        end

        // m1 write then m0 read-back of the same word.
        rst_pulse();
        drive(0, 0, 0, 0, 1, 0, 1, 3, 32'hDEADBEEF);
        #3;
        chk("t3_g1", bus.m1_gnt, 1);
        chk("t3_we", bus.mem_we, 1);
        chk("t3_din", bus.mem_din, 32'hDEADBEEF);
        cyc();
        chk("t3_no_rv1", bus.m1_rvalid, 0);
        drive(1, 0, 3, 0, 0, 0, 0, 0, 0);
        #3;
        chk("t3_g0", bus.m0_gnt, 1);
        cyc();
        chk("t3_rv0", bus.m0_rvalid, 1);
        chk("t3_rd0", bus.m0_rdata, 32'hDEADBEEF);
        exp_mem[3] = 32'hDEADBEEF;
        idle();

        // m0 alone: ten back-to-back reads.
        rv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 10 + i, 0, 0, 0, 0, 0, 0);
            #3;
            chk($sformatf("t5_g0_%0d", i), bus.m0_gnt, 1);
            chk($sformatf("t5_st_%0d", i), bus.cpu_stall, 0);
            cyc();
            if (bus.m0_rvalid) rv_cnt++;
            chk($sformatf("t5_rd_%0d", i), bus.m0_rdata, exp_mem[10 + i]);
        end
        idle();
        cyc();
        chk("t5_rv_count", 32'(rv_cnt), 10);
        chk("t5_rv_end", bus.m0_rvalid, 0);

        // Reset in the middle of a locked burst (counter at 4).
        rst_pulse();
        drive(0, 0, 0, 0, 1, 1, 0, 20, 0);
        cyc();
        bus.m0_req = 1;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk($sformatf("t6_g1_%0d", i), bus.m1_gnt, 1);
            chk($sformatf("t6_st_%0d", i), bus.cpu_stall, 1);
            cyc();
        end
        chk("t6_pre_rv1", bus.m1_rvalid, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_rv1", bus.m1_rvalid, 0);
        chk("t6_rst_rd1", bus.m1_rdata, 0);
        chk("t6_rst_g0", bus.m0_gnt, 1);
        chk("t6_rst_g1", bus.m1_gnt, 0);
        chk("t6_rst_st", bus.cpu_stall, 0);
        reset = 1'b1;
        #1;
        chk("t6_post_g0", bus.m0_gnt, 1);
        cyc();
        chk("t6_post_rv0", bus.m0_rvalid, 1);
        chk("t6_post_rd0", bus.m0_rdata, exp_mem[0]);
        idle();

        // Random traffic against the reference model.
        rst_pulse();
        last_win = -1;
        burst_on = 0;
        burst_n  = 0;
        e_rd0 = 0; e_rd1 = 0; e_rv0 = 0; e_rv1 = 0;
        for (int i = 0; i < 600; i++) begin
            bit r0, r1, lk, w0, w1;
            int a0, a1;
            logic [31:0] d0, d1;
            bit bmode;
            bmode = ((i / 16) % 3) == 0;
            r0 = $urandom_range(0, 3) != 0;
            r1 = bmode ? 1'b1 : ($urandom_range(0, 3) != 0);
            lk = bmode ? 1'b1 : ($urandom_range(0, 2) != 0);
            w0 = $urandom_range(0, 2) == 0;
            w1 = $urandom_range(0, 2) == 0;
            a0 = $urandom_range(0, 15);
            a1 = $urandom_range(0, 15);
            d0 = $urandom;
            d1 = $urandom;
            drive(r0, w0, a0, d0, r1, lk, w1, a1, d1);
            #3;
            w = pick(r0, r1);
            chk("rnd_g0", bus.m0_gnt, w == 0);
            chk("rnd_g1", bus.m1_gnt, w == 1);
            chk("rnd_st", bus.cpu_stall, r0 && w != 0);
            chk("rnd_we", bus.mem_we, (w == 0) ? w0 : (w == 1) ? w1 : 1'b0);
            if (w >= 0)
                chk("rnd_addr", bus.mem_addr, (w == 0) ? a0 : a1);
            e_rv0 = (w == 0) && !w0;
            e_rv1 = (w == 1) && !w1;
            if (e_rv0) e_rd0 = exp_mem[a0];
            if (e_rv1) e_rd1 = exp_mem[a1];
            if (w == 0 && w0) exp_mem[a0] = d0;
            if (w == 1 && w1) exp_mem[a1] = d1;
            if (w >= 0) last_win = w;
            if (w == 1 && lk) begin
                if (burst_on && r0 && burst_n < BM) burst_n++;
                burst_on = 1;
            end else begin
                burst_on = 0;
                burst_n  = 0;
            end
            cyc();
            chk("rnd_rv0", bus.m0_rvalid, e_rv0);
            chk("rnd_rv1", bus.m1_rvalid, e_rv1);
            chk("rnd_rd0", bus.m0_rdata, e_rd0);
            chk("rnd_rd1", bus.m1_rdata, e_rd1);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
